// File: rtl/axi_sram_reader_pkg.sv
// Shared constants and types for the sequential SRAM read engine.
// The response codes match the AXI-Lite SRAM controller's encoding.
package axi_sram_reader_pkg;

    // AXI read response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Read engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for start
        ST_ADDR = 2'd1,   // presenting arvalid once FIFO space is available
        ST_RESP = 2'd2,   // rready high, waiting for the single outstanding beat
        ST_FIN  = 2'd3    // one-cycle done pulse
    } state_t;

endpackage

// File: rtl/axi_sram_reader_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// The head word is visible on pop_data whenever empty is low; pop_data
// reads as zero while the FIFO is empty so downstream sees a clean bus.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;

    // Pushing into a full FIFO or popping an empty one is silently ignored
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; no reset so it can map onto RAM resources
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy registers; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_sram_reader.sv
// Sequential AXI-Lite read master: reads len consecutive words starting at
// base_addr, one outstanding beat at a time, into an output FIFO. A read
// address is only issued when the FIFO has room for its data, so the
// consumer may stall indefinitely without any risk of overflow.
module axi_sram_reader
    import axi_sram_reader_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int LEN_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    state_t                      state_q;
    state_t                      state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_d;
    logic [LEN_WIDTH-1:0]        remaining_q;
    logic [LEN_WIDTH-1:0]        remaining_d;
    logic                        err_q;
    logic                        err_d;

    logic                        start_ok;
    logic                        ar_fire;
    logic                        r_fire;
    logic                        last_word;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign ar_fire   = m_axi_arvalid && m_axi_arready;
    assign r_fire    = (state_q == ST_RESP) && m_axi_rvalid;
    assign last_word = (remaining_q == LEN_WIDTH'(1));

    // The full guard is redundant with the space check before AR, but keeps
    // the FIFO safe against a misbehaving slave returning unrequested data.
    assign fifo_push = r_fire && !fifo_full;
    assign fifo_pop  = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (m_axi_rdata),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? ST_ADDR : ST_FIN;
                end
            end
            ST_ADDR: begin
                if (ar_fire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axi_rvalid) begin
                    state_d = last_word ? ST_FIN : ST_ADDR;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; arvalid only depends on FIFO space, which can only grow
    // while in ADDR, so once raised it holds until the handshake
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            ST_ADDR: m_axi_arvalid = (fifo_count < DEPTH_C);
            ST_RESP: m_axi_rready  = 1'b1;
            ST_FIN:  done          = 1'b1;
            default: ;
        endcase
    end

    // Address, remaining-length and sticky error next-state values
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        if (start_ok) begin
            err_d = 1'b0;
            if (len != '0) begin
                addr_d      = base_addr;
                remaining_d = len;
            end
        end else if (r_fire) begin
            addr_d      = addr_q + AXI_ADDR_WIDTH'(1);
            remaining_d = remaining_q - LEN_WIDTH'(1);
            if (m_axi_rresp != RESP_OKAY) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

    assign m_axi_araddr = addr_q;
    assign err          = err_q;
    assign out_valid    = !fifo_empty;

endmodule

// File: doc/axi_sram_reader.md
# axi_sram_reader

Sequential read engine that sits directly upstream of the AXI-Lite SRAM controller as its read-channel master. Given a base word address and a length, it issues single-beat AXI-Lite reads for consecutive addresses. Returned words go into a small FIFO, which a streaming consumer such as a display/line fetcher drains through a valid/ready port. The engine issues a read only when FIFO space is guaranteed, so the consumer can stall freely.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 20, word address width (matches controller)
- AXI_DATA_WIDTH, 16, data word width
- LEN_WIDTH, 16, width of transfer length
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  AXI_ADDR_WIDTH  first word address
- len  in  LEN_WIDTH  number of words to read
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when the final read response is accepted
- err  out  1  sticky; set on any rresp≠OKAY, cleared by accepted start
- m_axi_araddr  out  AXI_ADDR_WIDTH  read address
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  AXI_DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- out_data  out  AXI_DATA_WIDTH  FIFO head word
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pop

## Operation
- States:
  - IDLE
  - ADDR: arvalid phase
  - RESP: rready phase
  - FIN: done pulse
- IDLE:
  - start with len≠0 latches addr←base_addr, remaining←len, clears err, goes to ADDR.
  - start with len=0 clears err and goes to FIN; no bus traffic.
- ADDR:
  - m_axi_arvalid = (fifo_count < FIFO_DEPTH); m_axi_araddr = addr.
  - Only pops occur in ADDR, so once arvalid rises it stays high until arready. This satisfies the AXI stability rule.
  - On arvalid&arready: go to RESP.
- RESP:
  - m_axi_rready=1.
  - On rvalid: push rdata into FIFO; if rresp≠2'b00, set err (data is still pushed).
  - Then addr←addr+1 (wraps mod 2^AXI_ADDR_WIDTH) and remaining←remaining−1.
  - If remaining was 1, go to FIN; else go to ADDR.
- FIN: done=1 for one cycle, then IDLE.
- At most one outstanding read. A push never overflows, because space was checked before AR was issued.
- FIFO pop on out_valid&out_ready in any state, including IDLE after done. Push and pop in the same cycle leave the count unchanged.
- start while busy is ignored.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0, err=0
  - arvalid=0, rready=0
  - FIFO empty: out_valid=0
  - araddr=0, out_data=0
- start at cycle N → busy=1 and arvalid=1 (if FIFO not full) at N+1.
- arready at cycle M → rready=1 at M+1.
- rvalid&rready at cycle K:
  - data visible at out_valid/out_data at K+1.
  - next arvalid at K+1, or done=1 at K+1 for the final word.
- done at cycle D → busy=0 at D+1.
- Throughput is bounded by the controller's handshake; the engine adds no stall cycles beyond the state steps above when the FIFO has space.
- Reset mid-transfer:
  - Aborts immediately, flushes the FIFO, drops arvalid/rready the next cycle.
  - The controller shares the same reset, so no stale response follows.

## Structure
- Shared package/include: RESP_OKAY=2'b00 and the state encodings (IDLE, ADDR, RESP, FIN), alongside the controller's RESP constant.
- Sub-module sync_fifo:
  - Parameters: width, depth.
  - Ports: push/pop, full/empty, count.
  - First-word fall-through.
  - Reusable by other streaming blocks.
- Top level: FSM, address/length counters, err flag.

## Test plan
- Reset, then start base=0x00010, len=4 with out_ready=1 and a simple SRAM model: araddr sequence 0x10,0x11,0x12,0x13; out_data matches model contents; done pulses once; err=0.
- len=0 start: done pulses at N+1, arvalid never asserts, busy high exactly one cycle.
- FIFO_DEPTH=8, len=12, out_ready=0: exactly 8 reads issue, then arvalid stays 0; raising out_ready resumes the remaining 4; all 12 words arrive in order.
- base=0xFFFFE, len=4: araddr wraps 0xFFFFE,0xFFFFF,0x00000,0x00001.
- Model returns rresp=2'b10 on word 2 of 3: err rises after that response, all 3 words are delivered, err clears on the next start.
- Reset asserted while in RESP with 3 words buffered: next cycle out_valid=0, busy=0, arvalid=0, rready=0; a new start then runs normally.
